// File: rtl/instruction_types.sv
// Shared instruction-level types: opcodes, the decoded instruction record and the
// issue controller state enum.
package instruction_types;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_AUIPC  = 7'h17;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6F;

  localparam logic [1:0] LS_NONE  = 2'd0;
  localparam logic [1:0] LS_LOAD  = 2'd1;
  localparam logic [1:0] LS_STORE = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [4:0]  rd_addr;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs2_imm;
    logic        branch;
    logic [1:0]  loadstore;
  } instruction_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } issue_state_t;

  function automatic logic opcode_legal(input logic [6:0] op);
    case (op)
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_STORE, OPCODE_OP,
      OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL: opcode_legal = 1'b1;
      default: opcode_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode.sv
// Combinational RV32I-style decoder. Register fields an instruction does not use are
// reported as x0 so they can never raise a scoreboard hazard.
module decode
  import instruction_types::*;
(
  input  logic [31:0]  i_instr,
  input  logic [31:0]  i_pc,
  output instruction_t o_instr,
  output logic         o_invalid
);

  logic [6:0] opcode;
  logic       has_rs1;
  logic       has_rs2;
  logic       has_rd;

  always_comb begin
    opcode  = i_instr[6:0];
    has_rs1 = !(opcode == OPCODE_LUI || opcode == OPCODE_AUIPC || opcode == OPCODE_JAL);
    has_rs2 = (opcode == OPCODE_OP) || (opcode == OPCODE_STORE) || (opcode == OPCODE_BRANCH);
    has_rd  = !(opcode == OPCODE_STORE || opcode == OPCODE_BRANCH);

    o_invalid = !opcode_legal(opcode);

    o_instr           = '0;
    o_instr.pc        = i_pc;
    o_instr.opcode    = opcode;
    o_instr.funct3    = i_instr[14:12];
    o_instr.funct7_b5 = i_instr[30];
    o_instr.rd_addr   = has_rd  ? i_instr[11:7]  : 5'd0;
    o_instr.rs1_addr  = has_rs1 ? i_instr[19:15] : 5'd0;
    o_instr.rs2_addr  = has_rs2 ? i_instr[24:20] : 5'd0;
    o_instr.rs2_imm   = (opcode != OPCODE_OP) && (opcode != OPCODE_BRANCH);
    o_instr.branch    = (opcode == OPCODE_BRANCH) || (opcode == OPCODE_JAL) ||
                        (opcode == OPCODE_JALR);

    if (opcode == OPCODE_LOAD) begin
      o_instr.loadstore = LS_LOAD;
    end else if (opcode == OPCODE_STORE) begin
      o_instr.loadstore = LS_STORE;
    end else begin
      o_instr.loadstore = LS_NONE;
    end

    case (opcode)
      OPCODE_STORE:  o_instr.imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      OPCODE_BRANCH: o_instr.imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
      OPCODE_LUI,
      OPCODE_AUIPC:  o_instr.imm = {i_instr[31:12], 12'd0};
      OPCODE_JAL:    o_instr.imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                    i_instr[20], i_instr[30:21], 1'b0};
      default:       o_instr.imm = {{20{i_instr[31]}}, i_instr[31:20]};
    endcase
  end

endmodule

// File: rtl/issue_ctrl.sv
// Single-slot decode/issue stage with a load-use scoreboard, branch redirect flush and
// an illegal-instruction trap handshake.
module issue_ctrl
  import instruction_types::*;
#(
  parameter int USE_SCOREBOARD = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_fetch_valid,
  input  logic [31:0]  i_fetch_instr,
  input  logic [31:0]  i_fetch_pc,
  output logic         o_fetch_ready,
  output logic         o_ex_valid,
  output instruction_t o_ex_instr,
  input  logic         i_ex_ready,
  input  logic         i_redirect,
  input  logic         i_wb_valid,
  input  logic [4:0]   i_wb_rd,
  output logic         o_trap,
  output logic [31:0]  o_trap_pc,
  input  logic         i_trap_ack
);

  issue_state_t state_q, state_d;
  logic         full_q, full_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  sb_q, sb_d;
  logic [31:0]  trap_pc_q, trap_pc_d;

  instruction_t dec_instr;
  logic         inst_invalid;
  logic         rs2_used;
  logic         hazard;
  logic         issue_fire;
  logic         fetch_fire;
  logic         sb_set;

  decode u_decode (
    .i_instr   (instr_q),
    .i_pc      (pc_q),
    .o_instr   (dec_instr),
    .o_invalid (inst_invalid)
  );

  assign o_ex_instr = dec_instr;
  assign o_trap     = (state_q == TRAP);
  assign o_trap_pc  = trap_pc_q;

  always_comb begin
    rs2_used      = !dec_instr.rs2_imm || dec_instr.branch || (dec_instr.loadstore != LS_NONE);
    hazard        = (USE_SCOREBOARD != 0) &&
                    (sb_q[dec_instr.rs1_addr] || (rs2_used && sb_q[dec_instr.rs2_addr]));
    o_ex_valid    = full_q && (state_q == RUN) && !inst_invalid && !hazard && !i_redirect;
    issue_fire    = o_ex_valid && i_ex_ready;
    o_fetch_ready = (state_q == RUN) && (!full_q || issue_fire);
    fetch_fire    = i_fetch_valid && o_fetch_ready;
    sb_set        = issue_fire && (dec_instr.loadstore != LS_NONE) && (dec_instr.rd_addr != 5'd0);
  end

  // Writeback clear is applied first so a same-cycle load issue to that register wins.
  always_comb begin
    sb_d = sb_q;
    if (i_wb_valid) begin
      sb_d[i_wb_rd] = 1'b0;
    end
    if (sb_set) begin
      sb_d[dec_instr.rd_addr] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    full_d    = full_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    trap_pc_d = trap_pc_q;
    case (state_q)
      RUN: begin
        if (i_redirect) begin
          full_d = 1'b0;
        end else if (full_q && inst_invalid) begin
          state_d   = TRAP;
          trap_pc_d = pc_q;
          full_d    = 1'b0;
        end else begin
          if (issue_fire) begin
            full_d = 1'b0;
          end
          if (fetch_fire) begin
            full_d  = 1'b1;
            instr_d = i_fetch_instr;
            pc_d    = i_fetch_pc;
          end
        end
      end
      TRAP: begin
        if (i_trap_ack) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= RUN;
      full_q    <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      sb_q      <= '0;
      trap_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      instr_q   <= instr_d;
      pc_q      <= pc_d;
      sb_q      <= sb_d;
      trap_pc_q <= trap_pc_d;
    end
  end

endmodule
